// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer for the OrgaSmall core.
// Owns the program counter and the retired-instruction counter, strobes
// instruction-register load, register-file write and flags write once per
// instruction, and stops the core on HLT or an unrecognised opcode.
module control_unit #(
    parameter int ADDR_SIZE   = 8,
    parameter int OPCODE_BITS = 5,
    parameter int COUNT_BITS  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [ADDR_SIZE-1:0]   imem_addr,
    input  logic                   imem_ack,
    output logic                   ir_load,
    input  logic [OPCODE_BITS-1:0] opcode,
    input  logic [ADDR_SIZE-1:0]   imm,
    input  logic                   flag_c,
    input  logic                   flag_z,
    input  logic                   flag_n,
    output logic                   reg_we,
    output logic                   wb_sel_imm,
    output logic                   flags_we,
    output logic [ADDR_SIZE-1:0]   pc,
    output logic                   halted,
    output logic                   illegal,
    output logic [COUNT_BITS-1:0]  inst_count
);

    localparam logic [OPCODE_BITS-1:0] OP_ADD = OPCODE_BITS'(5'h01);
    localparam logic [OPCODE_BITS-1:0] OP_ADC = OPCODE_BITS'(5'h02);
    localparam logic [OPCODE_BITS-1:0] OP_SUB = OPCODE_BITS'(5'h03);
    localparam logic [OPCODE_BITS-1:0] OP_AND = OPCODE_BITS'(5'h04);
    localparam logic [OPCODE_BITS-1:0] OP_OR  = OPCODE_BITS'(5'h05);
    localparam logic [OPCODE_BITS-1:0] OP_XOR = OPCODE_BITS'(5'h06);
    localparam logic [OPCODE_BITS-1:0] OP_CMP = OPCODE_BITS'(5'h07);
    localparam logic [OPCODE_BITS-1:0] OP_MOV = OPCODE_BITS'(5'h08);
    localparam logic [OPCODE_BITS-1:0] OP_SET = OPCODE_BITS'(5'h10);
    localparam logic [OPCODE_BITS-1:0] OP_JMP = OPCODE_BITS'(5'h14);
    localparam logic [OPCODE_BITS-1:0] OP_JC  = OPCODE_BITS'(5'h15);
    localparam logic [OPCODE_BITS-1:0] OP_JZ  = OPCODE_BITS'(5'h16);
    localparam logic [OPCODE_BITS-1:0] OP_JN  = OPCODE_BITS'(5'h17);
    localparam logic [OPCODE_BITS-1:0] OP_HLT = OPCODE_BITS'(5'h1F);

    localparam logic [COUNT_BITS-1:0] COUNT_MAX = {COUNT_BITS{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT,
        S_ILLEGAL
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_SIZE-1:0]    pc_q, pc_d;
    logic [COUNT_BITS-1:0]   count_q, count_d;

    logic dec_valid;
    logic dec_reg_we;
    logic dec_flags_we;
    logic dec_wb_imm;
    logic dec_taken;

    // Opcode classification and per-opcode strobe/jump decode (flags sampled live)
    always_comb begin
        dec_valid    = 1'b1;
        dec_reg_we   = 1'b0;
        dec_flags_we = 1'b0;
        dec_wb_imm   = 1'b0;
        dec_taken    = 1'b0;
        case (opcode)
            OP_ADD, OP_ADC, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                dec_reg_we   = 1'b1;
                dec_flags_we = 1'b1;
            end
            OP_CMP: dec_flags_we = 1'b1;
            OP_MOV: dec_reg_we   = 1'b1;
            OP_SET: begin
                dec_reg_we = 1'b1;
                dec_wb_imm = 1'b1;
            end
            OP_JMP: dec_taken = 1'b1;
            OP_JC:  dec_taken = flag_c;
            OP_JZ:  dec_taken = flag_z;
            OP_JN:  dec_taken = flag_n;
            default: dec_valid = 1'b0;
        endcase
    end

    // State, pc and retired-count registers; reset wins in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    // Next-state logic; pc and count only move at the end of EXEC
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (imem_ack) state_d = S_DECODE;
            S_DECODE: begin
                if (dec_valid)            state_d = S_EXEC;
                else if (opcode == OP_HLT) state_d = S_HALT;
                else                      state_d = S_ILLEGAL;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = dec_taken ? imm : pc_q + ADDR_SIZE'(1);
                if (count_q != COUNT_MAX) count_d = count_q + COUNT_BITS'(1);
            end
            S_HALT:    state_d = S_HALT;
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs from registered state; EXEC strobes gated by the opcode decode
    always_comb begin
        imem_req   = (state_q == S_FETCH);
        ir_load    = (state_q == S_FETCH) && imem_ack;
        reg_we     = (state_q == S_EXEC) && dec_reg_we;
        flags_we   = (state_q == S_EXEC) && dec_flags_we;
        wb_sel_imm = (state_q == S_EXEC) && dec_wb_imm;
        halted     = (state_q == S_HALT) || (state_q == S_ILLEGAL);
        illegal    = (state_q == S_ILLEGAL);
    end

    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign inst_count = count_q;

endmodule
